// File: rtl/vga_pkg.sv
// Shared types, mode timing table and write-list helpers for the VGA mode sequencer.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [15:0] h_res;
    logic [15:0] h_front_porch;
    logic [15:0] h_sync_pulse;
    logic [15:0] h_back_porch;
    logic [15:0] v_res;
    logic [15:0] v_front_porch;
    logic [15:0] v_sync_pulse;
    logic [15:0] v_back_porch;
  } vga_timing_t;

  localparam vga_timing_t VGA_MODES [4] = '{
    '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33},
    '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23},
    '{16'd1024, 16'd24,  16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29},
    '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720, 16'd5,  16'd5, 16'd20}
  };

  localparam logic [3:0] REG_H_RES         = 4'd0;
  localparam logic [3:0] REG_H_FRONT_PORCH = 4'd1;
  localparam logic [3:0] REG_H_SYNC_PULSE  = 4'd2;
  localparam logic [3:0] REG_H_BACK_PORCH  = 4'd3;
  localparam logic [3:0] REG_V_RES         = 4'd4;
  localparam logic [3:0] REG_V_FRONT_PORCH = 4'd5;
  localparam logic [3:0] REG_V_SYNC_PULSE  = 4'd6;
  localparam logic [3:0] REG_V_BACK_PORCH  = 4'd7;
  localparam logic [3:0] REG_INIT          = 4'd8;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [3:0] LAST_K        = 4'd9;

  // Step 0 and the final step both target init; steps 1..8 walk regs 0..7.
  function automatic logic [3:0] write_reg(input logic [3:0] k);
    if (k == 4'd0 || k >= LAST_K) return REG_INIT;
    return k - 4'd1;
  endfunction

  function automatic logic [15:0] write_data(input logic [1:0] mode, input logic [3:0] k);
    vga_timing_t t;
    logic [15:0] d;
    t = VGA_MODES[mode];
    d = '0;
    case (write_reg(k))
      REG_H_RES:         d = t.h_res;
      REG_H_FRONT_PORCH: d = t.h_front_porch;
      REG_H_SYNC_PULSE:  d = t.h_sync_pulse;
      REG_H_BACK_PORCH:  d = t.h_back_porch;
      REG_V_RES:         d = t.v_res;
      REG_V_FRONT_PORCH: d = t.v_front_porch;
      REG_V_SYNC_PULSE:  d = t.v_sync_pulse;
      REG_V_BACK_PORCH:  d = t.v_back_porch;
      REG_INIT:          d = (k == 4'd0) ? 16'd0 : 16'd1;
      default:           d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vga_mode_ctrl.sv
// Video-mode sequencer: programs init=0, the eight timing registers, then init=1
// over an AXI4-Lite write-only master, reporting completion or abort.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter logic [11:0] BASE_ADDR = 12'h000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_mode,
  output logic        done,
  output logic        err,
  output logic [1:0]  cur_mode,
  output logic        cfg_valid,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [11:0] m_awaddr,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  input  logic [1:0]  m_bresp
);

  state_e      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [1:0]  mode_q, mode_d;
  logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [11:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        done_q, done_d, err_q, err_d, cfg_valid_q, cfg_valid_d;
  logic [1:0]  cur_mode_q, cur_mode_d;

  logic        aw_hs, w_hs, load;
  logic [3:0]  load_k;
  logic [1:0]  load_mode;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      mode_q      <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_valid_q <= 1'b0;
      cur_mode_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      mode_q      <= mode_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_valid_q <= cfg_valid_d;
      cur_mode_q  <= cur_mode_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    mode_d      = mode_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    done_d      = 1'b0;
    err_d       = err_q;
    cfg_valid_d = cfg_valid_q;
    cur_mode_d  = cur_mode_q;
    load        = 1'b0;
    load_k      = k_q;
    load_mode   = mode_q;
    aw_hs       = awvalid_q && m_awready;
    w_hs        = wvalid_q && m_wready;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d      = req_mode;
          k_d         = '0;
          cfg_valid_d = 1'b0;
          state_d     = ST_WRITE;
          load        = 1'b1;
          load_k      = '0;
          load_mode   = req_mode;
        end
      end
      ST_WRITE: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Either channel may finish first; the current-cycle handshake counts too.
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_bvalid) begin
          bready_d = 1'b0;
          if (m_bresp != AXI_RESP_OKAY) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (k_q == LAST_K) begin
            done_d      = 1'b1;
            err_d       = 1'b0;
            cur_mode_d  = mode_q;
            cfg_valid_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            k_d     = k_q + 4'd1;
            state_d = ST_WRITE;
            load    = 1'b1;
            load_k  = k_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = BASE_ADDR + {6'd0, write_reg(load_k), 2'b00};
      wdata_d   = {16'd0, write_data(load_mode, load_k)};
      wstrb_d   = 4'hF;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign cur_mode  = cur_mode_q;
  assign cfg_valid = cfg_valid_q;
  assign m_awvalid = awvalid_q;
  assign m_awaddr  = awaddr_q;
  assign m_wvalid  = wvalid_q;
  assign m_wdata   = wdata_q;
  assign m_wstrb   = wstrb_q;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Bench for vga_mode_ctrl: randomized AXI slave, transaction-level reference model,
// and a second instance with BASE_ADDR=12'h100 sharing the same stimulus.
module tb_vga_mode_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_mode = 2'd0;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00;

  logic        req_ready, done, err, cfg_valid, m_awvalid, m_wvalid, m_bready;
  logic [1:0]  cur_mode;
  logic [11:0] m_awaddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;

  logic        b_req_ready, b_done, b_err, b_cfg_valid, b_awvalid, b_wvalid, b_bready;
  logic [1:0]  b_cur_mode;
  logic [11:0] b_awaddr;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;

  always #5 aclk = ~aclk;

  vga_mode_ctrl u_dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_mode(req_mode), .done(done), .err(err), .cur_mode(cur_mode), .cfg_valid(cfg_valid),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
  );

  vga_mode_ctrl #(.BASE_ADDR(12'h100)) u_dut_b (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_mode(req_mode), .done(b_done), .err(b_err), .cur_mode(b_cur_mode), .cfg_valid(b_cfg_valid),
    .m_awvalid(b_awvalid), .m_awready(m_awready), .m_awaddr(b_awaddr),
    .m_wvalid(b_wvalid), .m_wready(m_wready), .m_wdata(b_wdata), .m_wstrb(b_wstrb),
    .m_bvalid(m_bvalid), .m_bready(b_bready), .m_bresp(m_bresp)
  );

  int n_pass = 0, n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Mode timing in register order h_res..v_back_porch.
  int tm [4][8] = '{
    '{640, 16, 96, 48, 480, 10, 2, 33},
    '{800, 40, 128, 88, 600, 1, 4, 23},
    '{1024, 24, 136, 160, 768, 3, 6, 29},
    '{1280, 110, 40, 220, 720, 5, 5, 20}
  };

  function automatic int exp_reg(input int k);
    return (k == 0 || k == 9) ? 8 : k - 1;
  endfunction

  function automatic int exp_data(input int mode, input int k);
    if (k == 0) return 0;
    if (k == 9) return 1;
    return tm[mode][k - 1];
  endfunction

  // Reference model state and slave state.
  bit  m_idle = 1'b1;
  int  m_mode = 0, m_cur = 0, m_cfg = 0, m_err = 0;
  int  aw_n = 0, w_n = 0, b_n = 0, b_aw_n = 0, lat = 0;
  int  acc_cnt = 0, done_cnt = 0, done_lat = 0;
  bit  s_aw = 1'b0, s_w = 1'b0, b_pend = 1'b0, zw = 1'b1;
  int  aw_dly = 0, w_dly = 0, b_dly = 0, err_at = 99;
  int  cap_a[$], cap_d[$], cap_b[$];
  logic        p_awvalid = 1'b0, p_wvalid = 1'b0, p_bready = 1'b0, p_req_valid = 1'b0, pb_awvalid = 1'b0;
  logic [1:0]  p_req_mode = 2'd0;
  logic [11:0] p_awaddr = '0, pb_awaddr = '0;
  logic [31:0] p_wdata = '0;
  logic [3:0]  p_wstrb = '0;
  bit  hs_aw, hs_w, hs_b, e_done, up;

  always @(negedge aclk) begin
    if (!aresetn) begin
      m_idle = 1'b1; m_cur = 0; m_cfg = 0; m_err = 0;
      s_aw = 1'b0; s_w = 1'b0; b_pend = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      p_awvalid = 1'b0; p_wvalid = 1'b0; p_bready = 1'b0; p_req_valid = 1'b0; pb_awvalid = 1'b0;
    end else begin
      hs_aw = p_awvalid && m_awready;
      hs_w  = p_wvalid && m_wready;
      hs_b  = m_bvalid && p_bready;
      e_done = 1'b0;
      up = 1'b0;
      if (m_idle && p_req_valid) begin
        m_idle = 1'b0; m_mode = int'(p_req_mode); m_cfg = 0;
        aw_n = 0; w_n = 0; b_n = 0; b_aw_n = 0; lat = 0;
        cap_a.delete(); cap_d.delete(); cap_b.delete();
        acc_cnt++;
        up = 1'b1;
      end else lat++;
      if (hs_aw) begin
        chk("awaddr", 32'(p_awaddr), 32'(4 * exp_reg(aw_n)));
        cap_a.push_back(int'(p_awaddr));
        aw_n++; s_aw = 1'b1;
      end
      if (hs_w) begin
        chk("wdata", p_wdata, 32'(exp_data(m_mode, w_n)));
        chk("wstrb", 32'(p_wstrb), 32'hF);
        cap_d.push_back(int'(p_wdata));
        w_n++; s_w = 1'b1;
      end
      if (pb_awvalid && m_awready) begin
        chk("awaddr_base100", 32'(pb_awaddr), 32'(256 + 4 * exp_reg(b_aw_n)));
        cap_b.push_back(int'(pb_awaddr));
        b_aw_n++;
      end
      if (hs_b) begin
        if (m_bresp != 2'b00) begin
          e_done = 1'b1; m_err = 1; m_idle = 1'b1;
        end else begin
          b_n++;
          if (b_n == 10) begin
            e_done = 1'b1; m_err = 0; m_cur = m_mode; m_cfg = 1; m_idle = 1'b1;
          end else up = 1'b1;
        end
      end
      chk("req_ready", 32'(req_ready), 32'(m_idle));
      chk("done", 32'(done), 32'(e_done));
      chk("err", 32'(err), 32'(m_err));
      chk("cur_mode", 32'(cur_mode), 32'(m_cur));
      chk("cfg_valid", 32'(cfg_valid), 32'(m_cfg));
      chk("done_base100", 32'(b_done), 32'(e_done));
      if (up) chk("valids_up", 32'({m_awvalid, m_wvalid}), 32'h3);
      if (m_idle) chk("no_write_idle", 32'({m_awvalid, m_wvalid}), 32'h0);
      if (p_awvalid && !hs_aw) chk("aw_stable", 32'({m_awvalid, m_awaddr}), 32'({1'b1, p_awaddr}));
      if (p_wvalid && !hs_w) chk("w_stable", 32'(m_wvalid), 32'h1);
      if (p_wvalid && !hs_w) chk("wdata_stable", m_wdata, p_wdata);
      if (e_done) begin done_cnt++; done_lat = lat; end

      // Slave: independent random AW/W ready delays, B after both handshakes.
      if (zw) m_awready = 1'b1;
      else if (hs_aw) begin m_awready = 1'b0; aw_dly = int'($urandom_range(0, 5)); end
      else if (m_awvalid && !m_awready) begin
        if (aw_dly == 0) m_awready = 1'b1; else aw_dly--;
      end
      if (zw) m_wready = 1'b1;
      else if (hs_w) begin m_wready = 1'b0; w_dly = int'($urandom_range(0, 5)); end
      else if (m_wvalid && !m_wready) begin
        if (w_dly == 0) m_wready = 1'b1; else w_dly--;
      end
      if (s_aw && s_w) begin
        s_aw = 1'b0; s_w = 1'b0; b_pend = 1'b1;
        b_dly = zw ? 0 : int'($urandom_range(0, 5));
        chk("bready_in_resp", 32'(m_bready), 32'h1);
      end
      if (hs_b) begin m_bvalid = 1'b0; m_bresp = 2'b00; end
      if (b_pend && !m_bvalid) begin
        if (b_dly == 0) begin
          m_bvalid = 1'b1; m_bresp = (b_n == err_at) ? 2'b10 : 2'b00; b_pend = 1'b0;
        end else b_dly--;
      end

      p_awvalid = m_awvalid; p_awaddr = m_awaddr; p_wvalid = m_wvalid; p_wdata = m_wdata;
      p_wstrb = m_wstrb; p_bready = m_bready; p_req_valid = req_valid; p_req_mode = req_mode;
      pb_awvalid = b_awvalid; pb_awaddr = b_awaddr;
    end
  end

  task automatic wait_acc(input int start);
    for (int i = 0; i < 50; i++) begin
      @(posedge aclk); #1;
      if (acc_cnt != start) return;
    end
    chk("accept_timeout", 32'(acc_cnt), 32'(start + 1));
  endtask

  task automatic wait_done(input int maxc);
    int start;
    start = done_cnt;
    for (int i = 0; i < maxc; i++) begin
      @(posedge aclk); #1;
      if (done_cnt != start) return;
    end
    chk("done_timeout", 32'(done_cnt), 32'(start + 1));
  endtask

  task automatic request(input logic [1:0] mode);
    int start;
    start = acc_cnt;
    @(posedge aclk); #1;
    req_valid = 1'b1;
    req_mode = mode;
    wait_acc(start);
    req_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_valids", 32'({m_awvalid, m_wvalid, m_bready}), 32'h0);
    chk("rst_status", 32'({done, err, cfg_valid, cur_mode}), 32'h0);
    chk("rst_awaddr", 32'(m_awaddr), 32'h0);
    chk("rst_wdata", m_wdata, 32'h0);
    chk("rst_wstrb", 32'(m_wstrb), 32'h0);
  endtask

  int lit_a [10] = '{32, 0, 4, 8, 12, 16, 20, 24, 28, 32};
  int lit_d0 [10] = '{0, 640, 16, 96, 48, 480, 10, 2, 33, 1};
  int lit_d2 [10] = '{0, 1024, 24, 136, 160, 768, 3, 6, 29, 1};
  int lit_d3 [10] = '{0, 1280, 110, 40, 220, 720, 5, 5, 20, 1};

  initial begin
    int a0;
    repeat (3) @(posedge aclk);
    #1;
    chk_reset_outputs();
    aresetn = 1'b1;

    // Zero-wait slave, mode 0.
    zw = 1'b1;
    request(2'd0);
    wait_done(100);
    chk("latency", 32'(done_lat), 32'd20);
    chk("m0_status", 32'({err, cfg_valid, cur_mode}), 32'b0_1_00);
    chk("m0_count", 32'(cap_a.size() + cap_d.size() + cap_b.size()), 32'd30);
    for (int i = 0; i < 10 && i < cap_a.size() && i < cap_d.size() && i < cap_b.size(); i++) begin
      chk("m0_addr_lit", 32'(cap_a[i]), 32'(lit_a[i]));
      chk("m0_data_lit", 32'(cap_d[i]), 32'(lit_d0[i]));
      chk("m0_addr100_lit", 32'(cap_b[i]), 32'(lit_a[i] + 256));
    end

    // Random slave delays, mode 2.
    zw = 1'b0;
    request(2'd2);
    wait_done(1000);
    chk("m2_count", 32'(cap_d.size()), 32'd10);
    for (int i = 0; i < 10 && i < cap_d.size(); i++) chk("m2_data_lit", 32'(cap_d[i]), 32'(lit_d2[i]));
    request(2'd1);
    wait_done(1000);
    chk("m1_status", 32'({err, cfg_valid, cur_mode}), 32'b0_1_01);

    // SLVERR on the 4th write aborts the sequence.
    err_at = 3;
    request(2'd3);
    wait_done(1000);
    err_at = 99;
    repeat (5) @(posedge aclk);
    #1;
    chk("abort_aw_count", 32'(cap_a.size()), 32'd4);
    chk("abort_status", 32'({err, cfg_valid, cur_mode}), 32'b1_0_01);

    // Request held through a sequence with a different mode.
    a0 = acc_cnt;
    @(posedge aclk); #1;
    req_valid = 1'b1;
    req_mode = 2'd2;
    wait_acc(a0);
    req_mode = 2'd0;
    wait_done(1000);
    chk("held_single_accept", 32'(acc_cnt - a0), 32'd1);
    wait_acc(a0 + 1);
    req_valid = 1'b0;
    wait_done(1000);
    chk("held_second_mode", 32'({cfg_valid, cur_mode}), 32'b1_00);

    // Reset pulse during the 5th write, then a full sequence.
    zw = 1'b1;
    request(2'd1);
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk); #1;
      if (m_awvalid && b_n == 4) break;
      if (i == 99) chk("fifth_write_timeout", 32'(b_n), 32'd4);
    end
    aresetn = 1'b0;
    #1;
    chk_reset_outputs();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    request(2'd3);
    wait_done(100);
    chk("post_rst_count", 32'(cap_a.size() + cap_d.size()), 32'd20);
    for (int i = 0; i < 10 && i < cap_d.size(); i++) chk("m3_data_lit", 32'(cap_d[i]), 32'(lit_d3[i]));
    chk("post_rst_status", 32'({err, cfg_valid, cur_mode}), 32'b0_1_11);

    repeat (3) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
